// File: rtl/gshare_branch_predictor.sv
// gshare conditional-branch predictor: a table of CTR_W-bit saturating counters
// indexed by PC[IDX_W:1] XOR global history. Lookups are combinational. The
// speculative history is shifted at fetch, and the committed history is shifted
// at training. On a flush the speculative history is restored from the committed one.
// Optional feature macro: BP_STATS_EN (commit statistics counters).
module gshare_branch_predictor #(
    parameter int XLEN   = 32,
    parameter int IDX_W  = 8,
    parameter int HIST_W = 8,
    parameter int CTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic [XLEN-1:0]   fet_pc,
    input  logic              fet_br_valid,
    input  logic              rob_bp_enable,
    input  logic [XLEN-1:0]   rob_bp_inst_addr,
    input  logic [HIST_W-1:0] rob_bp_ghr,
    input  logic              rob_bp_jump,
    input  logic              rob_bp_correct,
    output logic              bp_pred,
    output logic [HIST_W-1:0] bp_ghr,
    output logic [XLEN-1:0]   bp_correct_cnt,
    output logic [XLEN-1:0]   bp_total_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_d [ENTRIES];
    logic [HIST_W-1:0] spec_ghr_q, spec_ghr_d;
    logic [HIST_W-1:0] arch_ghr_q, arch_ghr_d;
    logic [IDX_W-1:0]  f_idx, u_idx;

    // Shift a new outcome into the history. This also covers HIST_W == 1, because
    // the MSB of {h, b} is dropped by the truncating cast.
    function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] h,
                                                     input logic b);
        return HIST_W'({h, b});
    endfunction

    // Saturating increment/decrement of one counter.
    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c,
                                                  input logic up);
        logic [CTR_W-1:0] r;
        r = c;
        if (up && (c != {CTR_W{1'b1}})) r = c + CTR_W'(1);
        if (!up && (c != '0))           r = c - CTR_W'(1);
        return r;
    endfunction

    assign f_idx   = fet_pc[IDX_W:1] ^ IDX_W'(spec_ghr_q);
    assign u_idx   = rob_bp_inst_addr[IDX_W:1] ^ IDX_W'(rob_bp_ghr);
    assign bp_pred = ctr_q[f_idx][CTR_W-1];
    assign bp_ghr  = spec_ghr_q;

    // Next counter table: only the trained entry moves.
    always_comb begin
        ctr_d = ctr_q;
        if (rob_bp_enable) ctr_d[u_idx] = sat_step(ctr_q[u_idx], rob_bp_jump);
    end

    // Next history. The commit is applied before the flush, so the repair includes it.
    always_comb begin
        arch_ghr_d = arch_ghr_q;
        if (rob_bp_enable) arch_ghr_d = hist_shift(arch_ghr_q, rob_bp_jump);
        spec_ghr_d = spec_ghr_q;
        if (flush)             spec_ghr_d = arch_ghr_d;
        else if (fet_br_valid) spec_ghr_d = hist_shift(spec_ghr_q, bp_pred);
    end

    // Table and history registers. rdy=0 holds everything, including reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
                spec_ghr_q <= '0;
                arch_ghr_q <= '0;
            end else begin
                ctr_q      <= ctr_d;
                spec_ghr_q <= spec_ghr_d;
                arch_ghr_q <= arch_ghr_d;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [XLEN-1:0] total_cnt_q, total_cnt_d;
    logic [XLEN-1:0] correct_cnt_q, correct_cnt_d;

    // Statistics: count trained commits and the correctly predicted ones, wrapping.
    always_comb begin
        total_cnt_d   = total_cnt_q;
        correct_cnt_d = correct_cnt_q;
        if (rob_bp_enable) begin
            total_cnt_d = total_cnt_q + XLEN'(1);
            if (rob_bp_correct) correct_cnt_d = correct_cnt_q + XLEN'(1);
        end
    end

    // Statistics registers, same reset and enable rules as the table.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                total_cnt_q   <= '0;
                correct_cnt_q <= '0;
            end else begin
                total_cnt_q   <= total_cnt_d;
                correct_cnt_q <= correct_cnt_d;
            end
        end
    end

    assign bp_total_cnt   = total_cnt_q;
    assign bp_correct_cnt = correct_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{fet_pc[XLEN-1:IDX_W+1], fet_pc[0],
                           rob_bp_inst_addr[XLEN-1:IDX_W+1], rob_bp_inst_addr[0]};
`else
    assign bp_total_cnt   = '0;
    assign bp_correct_cnt = '0;

    logic unused_bits;
    assign unused_bits = ^{fet_pc[XLEN-1:IDX_W+1], fet_pc[0],
                           rob_bp_inst_addr[XLEN-1:IDX_W+1], rob_bp_inst_addr[0],
                           rob_bp_correct};
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor. It runs directed scenarios first,
// then randomized traffic, and compares the DUT against an integer-level table model.
module tb_gshare_branch_predictor;

    localparam int XLEN = 32, IDX_W = 8, HIST_W = 8, CTR_W = 2;
    localparam int ENTRIES = 1 << IDX_W;
    localparam int HNUM    = 1 << HIST_W;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int CHALF   = 1 << (CTR_W - 1);

    logic clk = 1'b0;
    logic rst, rdy, flush, fet_br_valid, rob_bp_enable, rob_bp_jump, rob_bp_correct;
    logic [XLEN-1:0] fet_pc, rob_bp_inst_addr;
    logic [HIST_W-1:0] rob_bp_ghr;
    logic bp_pred;
    logic [HIST_W-1:0] bp_ghr;
    logic [XLEN-1:0] bp_correct_cnt, bp_total_cnt;

    gshare_branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .fet_pc(fet_pc), .fet_br_valid(fet_br_valid),
        .rob_bp_enable(rob_bp_enable), .rob_bp_inst_addr(rob_bp_inst_addr),
        .rob_bp_ghr(rob_bp_ghr), .rob_bp_jump(rob_bp_jump), .rob_bp_correct(rob_bp_correct),
        .bp_pred(bp_pred), .bp_ghr(bp_ghr),
        .bp_correct_cnt(bp_correct_cnt), .bp_total_cnt(bp_total_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_ctr [ENTRIES];
    int          m_spec, m_arch;
    logic [31:0] m_tot, m_cor;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_shift(input int h, input int b);
        return (h * 2 + b) % HNUM;
    endfunction

    function automatic int m_pred();
        int idx;
        idx = ((fet_pc >> 1) % ENTRIES) ^ m_spec;
        return (m_ctr[idx] >= CHALF) ? 1 : 0;
    endfunction

    function automatic logic [31:0] exp_stat(input logic [31:0] v);
`ifdef BP_STATS_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    // Apply one clock edge to the model, using the current inputs.
    task automatic model_edge();
        int p, na, ui;
        if (!rdy) return;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 0;
            m_spec = 0; m_arch = 0; m_tot = 0; m_cor = 0;
            return;
        end
        p  = m_pred();
        na = m_arch;
        if (rob_bp_enable) begin
            ui = ((rob_bp_inst_addr >> 1) % ENTRIES) ^ int'(rob_bp_ghr);
            if (rob_bp_jump) m_ctr[ui] = (m_ctr[ui] + 1 > CMAX) ? CMAX : m_ctr[ui] + 1;
            else             m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
            na = m_shift(m_arch, int'(rob_bp_jump));
            m_tot = m_tot + 1;
            if (rob_bp_correct) m_cor = m_cor + 1;
        end
        if (flush)             m_spec = na;
        else if (fet_br_valid) m_spec = m_shift(m_spec, p);
        m_arch = na;
    endtask

    // Check outputs against the model, then advance one cycle.
    task automatic tick();
        #1;
        chk("pred", bp_pred, m_pred());
        chk("ghr", bp_ghr, m_spec);
        chk("total", bp_total_cnt, exp_stat(m_tot));
        chk("correct", bp_correct_cnt, exp_stat(m_cor));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; fet_br_valid = 0; rob_bp_enable = 0;
        rob_bp_jump = 0; rob_bp_correct = 0; rob_bp_inst_addr = '0; rob_bp_ghr = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1;
        @(posedge clk); model_edge(); #1;
        rst = 0;
    endtask

    task automatic commit(input logic [31:0] pc, input int ghr, input logic j, input logic c);
        rob_bp_enable = 1; rob_bp_inst_addr = pc; rob_bp_ghr = HIST_W'(ghr);
        rob_bp_jump = j; rob_bp_correct = c;
        tick();
        rob_bp_enable = 0;
    endtask

    initial begin
        idle(); fet_pc = '0;
        m_spec = 0; m_arch = 0; m_tot = 0; m_cor = 0;
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 0;
        do_reset();

        // Reset state
        fet_pc = 32'h0;   #1 chk("rst_pred_0", bp_pred, 0);
        fet_pc = 32'h100; #1 chk("rst_pred_100", bp_pred, 0);
        fet_pc = 32'hFFE; #1 chk("rst_pred_ffe", bp_pred, 0);
        chk("rst_ghr", bp_ghr, 0);
        chk("rst_total", bp_total_cnt, 0);
        chk("rst_correct", bp_correct_cnt, 0);

        // Saturation at index 0x80
        fet_pc = 32'h100;
        commit(32'h100, 0, 1, 1); chk("sat_c1", bp_pred, 0);
        commit(32'h100, 0, 1, 1); chk("sat_c2", bp_pred, 1);
        commit(32'h100, 0, 1, 1); chk("sat_c3", bp_pred, 1);
        commit(32'h100, 0, 1, 1); chk("sat_c4", bp_pred, 1);
        commit(32'h100, 0, 0, 0); chk("sat_dn", bp_pred, 1);

        // Freeze: commits and reset are ignored while rdy=0
        rdy = 0; rst = 1;
        for (int i = 0; i < 3; i++) commit(32'h100, 0, 0, 0);
        rdy = 1; rst = 0;
        chk("frz_pred", bp_pred, 1);
        chk("frz_ghr", bp_ghr, 0);
        chk("frz_total", bp_total_cnt, exp_stat(32'd5));
        commit(32'h100, 0, 0, 0); chk("frz_resume", bp_pred, 0);

        // Statistics
        do_reset();
        for (int i = 0; i < 10; i++) commit(32'h200 + 32'(i * 2), i, i[0], (i < 7) ? 1'b1 : 1'b0);
        chk("stat_total", bp_total_cnt, exp_stat(32'd10));
        chk("stat_correct", bp_correct_cnt, exp_stat(32'd7));

        // Speculative history shift
        do_reset();
        fet_pc = 32'h100;
        for (int i = 0; i < 3; i++) commit(32'h100, 0, 1, 1);
        chk("spec_ghr0", bp_ghr, 8'h00);
        chk("spec_pred0", bp_pred, 1);
        fet_br_valid = 1;
        tick();
        chk("spec_ghr1", bp_ghr, 8'h01);
        chk("spec_pred1", bp_pred, 0);
        tick();
        fet_br_valid = 0;
        chk("spec_ghr2", bp_ghr, 8'h02);

        // Flush repair with a same-cycle commit and fetch
        do_reset();
        fet_pc = 32'h40;
        commit(32'h10, 0, 1, 1);
        commit(32'h10, 0, 0, 1);
        fet_br_valid = 1;
        for (int i = 0; i < 3; i++) tick();
        flush = 1;
        commit(32'h10, 7, 1, 0);
        flush = 0; fet_br_valid = 0;
        chk("flush_ghr", bp_ghr, 8'h05);
        fet_pc = 32'h10 ^ 32'(7 << 1);
        #1 chk("flush_trained", bp_pred, 0);
        commit(32'h10, 7, 1, 1);
        fet_pc = 32'h10 ^ 32'((7 ^ 5) << 1);
        #1 chk("flush_trained2", bp_pred, m_pred());

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rdy              = ($urandom_range(0, 9) != 0);
            rst              = ($urandom_range(0, 49) == 0);
            flush            = ($urandom_range(0, 9) == 0);
            fet_br_valid     = $urandom_range(0, 1) == 1;
            rob_bp_enable    = $urandom_range(0, 1) == 1;
            rob_bp_jump      = $urandom_range(0, 2) != 0;
            rob_bp_correct   = $urandom_range(0, 1) == 1;
            fet_pc           = 32'($urandom_range(0, 63)) << 1;
            rob_bp_inst_addr = 32'($urandom_range(0, 63)) << 1;
            rob_bp_ghr       = HIST_W'($urandom_range(0, 15));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
